// File: rtl/if_stage_if.sv
// if_stage_if: fetch-stage buses (imem request/response, execute redirect, decode handoff)
interface if_stage_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] inst;
  logic [63:0] inst_addr;
  modport master (
    output imem_req_valid, imem_req_addr, id_valid, inst, inst_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );
  modport slave (
    input  imem_req_valid, imem_req_addr, id_valid, inst, inst_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );
endinterface

// File: rtl/if_stage.sv
// if_stage: in-order instruction fetch with credit-limited requests, buffered responses and redirect flush
module if_stage #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
  parameter int          DEPTH    = 2
) (
  input logic        clk,
  input logic        rst,
  if_stage_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int W  = $clog2(DEPTH) + 1;
  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] RUN   = 2'd1;
  localparam logic [1:0] DRAIN = 2'd2;
  logic [1:0]    state, state_nxt;
  logic [63:0]   fetch_pc;
  logic [W-1:0]  outstanding, drop_cnt, fifo_count, drop_nxt;
  logic [W:0]    credit_sum;
  logic [AW-1:0] tag_wr, tag_rd, fifo_wr, fifo_rd;
  logic [63:0]   tag_q [DEPTH];
  logic [95:0]   fifo_q [DEPTH];
  logic          redir, accept, rsp_drop, rsp_keep, pop;
  assign redir      = bus.redirect_valid;
  assign credit_sum = (W+1)'(outstanding) + (W+1)'(drop_cnt) + (W+1)'(fifo_count);
  assign bus.imem_req_valid = (state != IDLE) & ~redir & (credit_sum < (W+1)'(DEPTH));
  // address is zeroed while no request is offered so every output reads 0 in reset/idle
  assign bus.imem_req_addr  = bus.imem_req_valid ? fetch_pc : '0;
  assign accept   = bus.imem_req_valid & bus.imem_req_ready;
  assign rsp_drop = bus.imem_rsp_valid & (drop_cnt != '0);
  assign rsp_keep = bus.imem_rsp_valid & (drop_cnt == '0);
  assign bus.id_valid = (fifo_count != '0) & ~redir;
  assign pop = bus.id_valid & bus.id_ready;
  assign {bus.inst_addr, bus.inst} = bus.id_valid ? fifo_q[fifo_rd] : '0;
  // a redirect converts every in-flight request into a pending discard; a response that same cycle retires one of them
  assign drop_nxt  = redir ? drop_cnt + outstanding - W'(bus.imem_rsp_valid) : drop_cnt - W'(rsp_drop);
  assign state_nxt = (state == IDLE) ? RUN : (drop_nxt != '0) ? DRAIN : RUN;
  // control state: pc, credit counters and queue pointers; redirect flushes everything and takes priority
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      fifo_count  <= '0;
      tag_wr      <= '0;
      tag_rd      <= '0;
      fifo_wr     <= '0;
      fifo_rd     <= '0;
    end else begin
      state    <= state_nxt;
      drop_cnt <= drop_nxt;
      if (redir) begin
        fetch_pc    <= bus.redirect_pc & ~64'd3;
        outstanding <= '0;
        fifo_count  <= '0;
        tag_wr      <= '0;
        tag_rd      <= '0;
        fifo_wr     <= '0;
        fifo_rd     <= '0;
      end else begin
        outstanding <= outstanding + W'(accept) - W'(rsp_keep);
        fifo_count  <= fifo_count + W'(rsp_keep) - W'(pop);
        if (accept) begin
          fetch_pc <= fetch_pc + 64'd4;
          tag_wr   <= tag_wr + AW'(1);
        end
        if (rsp_keep) begin
          tag_rd  <= tag_rd + AW'(1);
          fifo_wr <= fifo_wr + AW'(1);
        end
        if (pop) fifo_rd <= fifo_rd + AW'(1);
      end
    end
  end
  // storage: request address tags and {pc, instruction} entries awaiting decode
  always_ff @(posedge clk) begin
    if (accept) tag_q[tag_wr] <= fetch_pc;
    if (rsp_keep & ~redir) fifo_q[fifo_wr] <= {tag_q[tag_rd], bus.imem_rsp_data};
  end
  rsp_without_request_a: assert property (@(posedge clk) disable iff (!rst)
    !(bus.imem_rsp_valid && outstanding == '0 && drop_cnt == '0));
endmodule
